// File: rtl/reg_arb_pkg.sv
// ----------------------------------------------------------------------------
// reg_arb_pkg
//   Shared types and constants for the two-requester register-bus arbiter.
//
//   Contents:
//     ADDR_W / DATA_W   width of the register-bus address and data fields
//     N_REQ             number of requesters served by the arbiter
//     TIMEOUT_RD_DATA   read value returned to a requester whose command
//                       timed out (used only when REG_ARB_TIMEOUT_EN is set)
//     arb_state_t       arbiter FSM state encoding (IDLE / BUSY / RESP)
//     bus_cmd_t         one register-bus command (direction, address, data)
// ----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_REQ  = 2;

    localparam logic [DATA_W-1:0] TIMEOUT_RD_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Packed so a whole command can be registered onto the bus in one step.
    typedef struct packed {
        logic              wr1rd0;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin selector. Purely combinational; the caller owns the
//   "last granted" state and only consults the result when a grant is taken.
//
//   Ports:
//     valid [1:0]  in   pending request per requester
//     last         in   index of the requester granted most recently
//     grant        out  index of the requester that wins this cycle
//                       (0 when nothing is pending; caller ignores it then)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Contention: the requester that did not win last time goes now.
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// ----------------------------------------------------------------------------
// reg_bus_arbiter
//   Shares one register bus between two requesters (r0, r1). A command is
//   granted in IDLE, held on the bus in BUSY until m_ack, and completed with a
//   one-cycle done pulse in RESP. Contention is resolved round-robin.
//
//   Optional feature (compile-time macro REG_ARB_TIMEOUT_EN):
//     defined   - an 8-bit counter bounds BUSY to TIMEOUT_CYCLES cycles; on
//                 expiry the requester gets done with err=1 and rd_data=0xFF.
//                 An ack arriving on the expiry edge wins (err=0).
//     undefined - no counter, err outputs tied to 0, BUSY waits forever.
//
//   Parameters:
//     TIMEOUT_CYCLES  max BUSY cycles to wait for m_ack (2..255)
//
//   Ports:
//     clk                      in   single clock, rising edge
//     resetb                   in   asynchronous active-low reset
//     rN_valid                 in   command pending, held until rN_done
//     rN_wr1rd0                in   1 = write, 0 = read
//     rN_addr [7:0]            in   target address
//     rN_data [7:0]            in   write data
//     rN_done                  out  one-cycle completion pulse
//     rN_err                   out  timeout flag, meaningful with rN_done
//     rN_rd_data [7:0]         out  read result, meaningful with rN_done
//     m_req                    out  bus command valid
//     m_wr1rd0/m_addr/m_data   out  bus command fields
//     m_ack                    in   bus acknowledge (only honoured in BUSY)
//     m_rd_data [7:0]          in   bus read data, valid alongside m_ack
// ----------------------------------------------------------------------------
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetb,

    input  logic              r0_valid,
    input  logic              r0_wr1rd0,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_data,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rd_data,

    input  logic              r1_valid,
    input  logic              r1_wr1rd0,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rd_data,

    output logic              m_req,
    output logic              m_wr1rd0,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rd_data
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("reg_bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    // ------------------------------------------------------------------
    // Requester inputs gathered into indexable form
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] valid_vec;
    bus_cmd_t         cmd_vec [N_REQ];

    assign valid_vec  = {r1_valid, r0_valid};
    assign cmd_vec[0] = {r0_wr1rd0, r0_addr, r0_data};
    assign cmd_vec[1] = {r1_wr1rd0, r1_addr, r1_data};

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    arb_state_t state_reg;
    arb_state_t state_next;
    logic       last_grant_reg;   // 1 after reset so r0 wins the first tie
    logic       winner_reg;       // requester owning the current transaction
    logic       m_req_reg;
    bus_cmd_t   m_cmd_reg;

    logic       grant;
    logic       grant_fire;       // IDLE edge that launches a command
    logic       ack_fire;         // BUSY edge that completes on m_ack
    logic       timeout_hit;      // BUSY edge that completes on expiry
    logic       finish;           // any BUSY -> RESP edge

    rr_arb2 u_rr_arb2 (
        .valid (valid_vec),
        .last  (last_grant_reg),
        .grant (grant)
    );

    assign grant_fire = (state_reg == ST_IDLE) && (|valid_vec);
    assign ack_fire   = (state_reg == ST_BUSY) && m_ack;
    assign finish     = ack_fire || timeout_hit;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_fire) state_next = ST_BUSY;
            ST_BUSY: if (finish)     state_next = ST_RESP;
            ST_RESP:                 state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            winner_reg     <= 1'b0;
            m_req_reg      <= 1'b0;
            m_cmd_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_fire) begin
                winner_reg     <= grant;
                last_grant_reg <= grant;
                m_cmd_reg      <= cmd_vec[grant];
                m_req_reg      <= 1'b1;
            end else if (finish) begin
                // Command fields stay parked on the bus; only m_req drops.
                m_req_reg <= 1'b0;
            end
        end
    end

    assign m_req    = m_req_reg;
    assign m_wr1rd0 = m_cmd_reg.wr1rd0;
    assign m_addr   = m_cmd_reg.addr;
    assign m_data   = m_cmd_reg.data;

    // ------------------------------------------------------------------
    // BUSY timeout
    // ------------------------------------------------------------------
`ifdef REG_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt_reg;
    logic [7:0] tmo_cnt_inc;
    logic       resp_err;

    assign tmo_cnt_inc = tmo_cnt_reg + 8'd1;

    // The !m_ack term gives an ack on the expiry edge priority over the
    // timeout, so that transaction completes normally with err=0.
    assign timeout_hit = (state_reg == ST_BUSY) && !m_ack
                         && (tmo_cnt_inc == TMO_LIMIT);
    assign resp_err    = timeout_hit;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tmo_cnt_reg <= 8'd0;
        end else if (grant_fire) begin
            tmo_cnt_reg <= 8'd0;
        end else if ((state_reg == ST_BUSY) && !m_ack) begin
            tmo_cnt_reg <= tmo_cnt_inc;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Value delivered to the winner at the BUSY -> RESP edge.
    logic [DATA_W-1:0] resp_data;
    assign resp_data = timeout_hit      ? TIMEOUT_RD_DATA :
                       m_cmd_reg.wr1rd0 ? '0              : m_rd_data;

    // ------------------------------------------------------------------
    // Per-requester response registers. rd_data/err only load on that
    // requester's own completion, so they hold between its done pulses.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]  done_vec;
    logic [N_REQ-1:0]  err_vec;
    logic [DATA_W-1:0] rd_data_vec [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            localparam logic IDX = 1'(gi);

            logic              hit;
            logic              done_reg;
            logic [DATA_W-1:0] rd_data_reg;

            assign hit = finish && (winner_reg == IDX);

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    done_reg    <= 1'b0;
                    rd_data_reg <= '0;
                end else begin
                    // finish only occurs in BUSY, so done self-clears in RESP.
                    done_reg <= hit;
                    if (hit) begin
                        rd_data_reg <= resp_data;
                    end
                end
            end

            assign done_vec[gi]    = done_reg;
            assign rd_data_vec[gi] = rd_data_reg;

`ifdef REG_ARB_TIMEOUT_EN
            logic err_reg;

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    err_reg <= 1'b0;
                end else if (hit) begin
                    err_reg <= resp_err;
                end
            end

            assign err_vec[gi] = err_reg;
`else
            assign err_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    assign r0_done    = done_vec[0];
    assign r1_done    = done_vec[1];
    assign r0_err     = err_vec[0];
    assign r1_err     = err_vec[1];
    assign r0_rd_data = rd_data_vec[0];
    assign r1_rd_data = rd_data_vec[1];

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_bus_arbiter
//   Directed and randomized stimulus for reg_bus_arbiter. A behavioural bus
//   slave (256-byte memory) answers the bus; a transaction-level model
//   predicts the round-robin winner, bus command, read data and the held
//   rd_data/err values of each requester. Timeout checks run when the bench
//   is compiled with REG_ARB_TIMEOUT_EN (TIMEOUT_CYCLES = 4).
// ----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int TMO = 4;
`ifdef REG_ARB_TIMEOUT_EN
    localparam int MAX_DELAY = TMO;
`else
    localparam int MAX_DELAY = 6;
`endif

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_wr = 2'b00;
    logic [7:0] req_addr [2];
    logic [7:0] req_data [2];
    logic       m_ack = 1'b0;

    wire        r0_done, r1_done, r0_err, r1_err;
    wire [7:0]  r0_rd_data, r1_rd_data;
    wire        m_req, m_wr1rd0;
    wire [7:0]  m_addr, m_data;

    logic [7:0] mem [256];
    wire  [7:0] m_rd_data = mem[m_addr];

    // Model state
    int         model_last;
    logic [7:0] exp_rd  [2];
    logic       exp_err [2];
    int         txn_n = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .r0_valid   (req_valid[0]),
        .r0_wr1rd0  (req_wr[0]),
        .r0_addr    (req_addr[0]),
        .r0_data    (req_data[0]),
        .r0_done    (r0_done),
        .r0_err     (r0_err),
        .r0_rd_data (r0_rd_data),
        .r1_valid   (req_valid[1]),
        .r1_wr1rd0  (req_wr[1]),
        .r1_addr    (req_addr[1]),
        .r1_data    (req_data[1]),
        .r1_done    (r1_done),
        .r1_err     (r1_err),
        .r1_rd_data (r1_rd_data),
        .m_req      (m_req),
        .m_wr1rd0   (m_wr1rd0),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_ack      (m_ack),
        .m_rd_data  (m_rd_data)
    );

    function automatic logic get_done(input int i);
        return (i == 1) ? r1_done : r0_done;
    endfunction

    function automatic logic get_err(input int i);
        return (i == 1) ? r1_err : r0_err;
    endfunction

    function automatic logic [7:0] get_rd(input int i);
        return (i == 1) ? r1_rd_data : r0_rd_data;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_last = 1;
        exp_rd[0]  = 8'h00;
        exp_rd[1]  = 8'h00;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
    endtask

    task automatic set_cmd(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_wr[k]    = wr;
        req_addr[k]  = a;
        req_data[k]  = d;
        req_valid[k] = 1'b1;
    endtask

    // Runs one transaction from IDLE (entered at posedge+1 with valids
    // already driven) and ends at posedge+1 of the following IDLE cycle.
    task automatic serve(input int ack_delay, input bit keep_valid);
        int         w;
        int         o;
        logic       a_wr;
        logic [7:0] a_addr, a_data, rd_exp;

        if (req_valid == 2'b11) w = 1 - model_last;
        else if (req_valid[1])  w = 1;
        else                    w = 0;
        o      = 1 - w;
        a_wr   = req_wr[w];
        a_addr = req_addr[w];
        a_data = req_data[w];

        @(posedge clk); #1;
        chk("grant_m_req",  m_req,    1);
        chk("grant_m_wr",   m_wr1rd0, a_wr);
        chk("grant_m_addr", m_addr,   a_addr);
        chk("grant_m_data", m_data,   a_data);
        chk("grant_done",   {r1_done, r0_done}, 0);

        for (int i = 1; i < ack_delay; i++) begin
            @(posedge clk); #1;
            chk("busy_m_req",  m_req,  1);
            chk("busy_m_addr", m_addr, a_addr);
            chk("busy_done",   {r1_done, r0_done}, 0);
        end

        rd_exp = a_wr ? 8'h00 : mem[a_addr];
        m_ack  = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        if (a_wr) mem[a_addr] = a_data;

        chk("resp_m_req",     m_req,       0);
        chk("resp_done_win",  get_done(w), 1);
        chk("resp_done_oth",  get_done(o), 0);
        chk("resp_rd_data",   get_rd(w),   rd_exp);
        chk("resp_err",       get_err(w),  0);
        chk("hold_rd_oth",    get_rd(o),   exp_rd[o]);
        chk("hold_err_oth",   get_err(o),  exp_err[o]);

        exp_rd[w]  = rd_exp;
        exp_err[w] = 1'b0;
        model_last = w;
        txn_n++;
        $display("txn %0d: r%0d %s addr=0x%02h wdata=0x%02h rdata=0x%02h ack_delay=%0d",
                 txn_n, w, a_wr ? "WR" : "RD", a_addr, a_data, rd_exp, ack_delay);

        if (!keep_valid) req_valid[w] = 1'b0;

        @(posedge clk); #1;
        chk("idle_m_req",   m_req, 0);
        chk("idle_done",    {r1_done, r0_done}, 0);
        chk("idle_rd_hold", get_rd(w), exp_rd[w]);
    endtask

    // Bound on total runtime.
    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        req_addr[0] = 8'h00; req_addr[1] = 8'h00;
        req_data[0] = 8'h00; req_data[1] = 8'h00;
        model_reset();

        // ---------------- Reset state ----------------
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req",    m_req,    0);
        chk("rst_m_wr",     m_wr1rd0, 0);
        chk("rst_m_addr",   m_addr,   0);
        chk("rst_m_data",   m_data,   0);
        chk("rst_done",     {r1_done, r0_done}, 0);
        chk("rst_err",      {r1_err, r0_err}, 0);
        chk("rst_rd_data",  {r1_rd_data, r0_rd_data}, 0);
        resetb = 1'b1;

        // ---------------- m_ack outside BUSY is ignored ----------------
        m_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_ack = 1'b0;
        chk("idle_ack_m_req", m_req, 0);
        chk("idle_ack_done",  {r1_done, r0_done}, 0);

        // ---------------- Write then read back ----------------
        set_cmd(0, 1'b1, 8'h00, 8'hA5);
        serve(2, 1'b0);
        set_cmd(0, 1'b0, 8'h00, 8'h00);
        serve(1, 1'b0);
        chk("readback_a5", r0_rd_data, 8'hA5);

        // ---------------- Tie handling from reset ----------------
        resetb = 1'b0;
        model_reset();
        @(posedge clk); #1;
        resetb = 1'b1;
        set_cmd(0, 1'b0, 8'h10, 8'h00);
        set_cmd(1, 1'b0, 8'h11, 8'h00);
        serve(1, 1'b0);
        chk("tie1_r0_first", model_last, 0);
        serve(2, 1'b0);
        chk("tie1_r1_second", model_last, 1);
        set_cmd(0, 1'b0, 8'h12, 8'h00);
        set_cmd(1, 1'b0, 8'h13, 8'h00);
        serve(1, 1'b0);
        serve(1, 1'b0);

        // ---------------- r1 read with specific bus data ----------------
        mem[8'h02] = 8'h50;
        set_cmd(1, 1'b0, 8'h02, 8'h00);
        serve(3, 1'b0);
        chk("r1_rd_0x50", r1_rd_data, 8'h50);

        // ---------------- Timeout / no-timeout behaviour ----------------
`ifdef REG_ARB_TIMEOUT_EN
        set_cmd(0, 1'b0, 8'h05, 8'h00);
        @(posedge clk); #1;
        chk("tmo_grant", m_req, 1);
        for (int i = 1; i < TMO; i++) begin
            @(posedge clk); #1;
            chk("tmo_busy_m_req", m_req, 1);
            chk("tmo_busy_done",  r0_done, 0);
        end
        @(posedge clk); #1;
        chk("tmo_m_req_drop", m_req,      0);
        chk("tmo_done",       r0_done,    1);
        chk("tmo_err",        r0_err,     1);
        chk("tmo_rd_ff",      r0_rd_data, 8'hFF);
        chk("tmo_other_done", r1_done,    0);
        $display("txn %0d: r0 RD addr=0x05 timed out", ++txn_n);
        req_valid[0] = 1'b0;
        exp_rd[0]  = 8'hFF;
        exp_err[0] = 1'b1;
        model_last = 0;
        @(posedge clk); #1;
        chk("tmo_done_clear", r0_done, 0);
        chk("tmo_err_hold",   r0_err,  1);
        // Ack on the expiry edge wins over the timeout.
        set_cmd(0, 1'b0, 8'h06, 8'h00);
        serve(TMO, 1'b0);
`else
        set_cmd(0, 1'b0, 8'h05, 8'h00);
        serve(20, 1'b0);
`endif

        // ---------------- Reset during BUSY ----------------
        set_cmd(0, 1'b0, 8'h03, 8'h00);
        @(posedge clk); #1;
        chk("rstb_grant", m_req, 1);
        @(posedge clk); #1;
        resetb = 1'b0;
        #1;
        chk("rstb_m_req_now", m_req, 0);
        chk("rstb_m_addr",    m_addr, 0);
        chk("rstb_done",      {r1_done, r0_done}, 0);
        chk("rstb_rd",        r0_rd_data, 0);
        model_reset();
        @(posedge clk); #1;
        chk("rstb_hold_m_req", m_req, 0);
        chk("rstb_hold_done",  {r1_done, r0_done}, 0);
        resetb = 1'b1;
        serve(2, 1'b0);
        chk("rstb_regrant_r0", model_last, 0);

        // ---------------- Randomized traffic ----------------
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_valid[k] && ($urandom_range(0, 1) == 1))
                    set_cmd(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                            8'($urandom));
            end
            if (req_valid == 2'b00) begin
                int k2;
                k2 = int'($urandom_range(0, 1));
                set_cmd(k2, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                        8'($urandom));
            end
            serve(int'($urandom_range(1, MAX_DELAY)), ($urandom_range(0, 3) == 0));
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("final_idle_m_req", m_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles to wait for m_ack; legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports r0_valid, r1_valid  input  1 each  requester command pending; held stable until that requester's done.
REQ-005 SHALL have ports r0_wr1rd0, r1_wr1rd0  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports r0_addr, r1_addr  input  8 each  register/memory address.
REQ-007 SHALL have ports r0_data, r1_data  input  8 each  write data.
REQ-008 SHALL have ports r0_done, r1_done  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports r0_err, r1_err  output  1 each  timeout flag, valid only with done.
REQ-010 SHALL have ports r0_rd_data, r1_rd_data  output  8 each  read result, valid only with done.
REQ-011 SHALL have ports m_req, m_wr1rd0, m_addr, m_data  output  1/1/8/8  shared register-bus command.
REQ-012 SHALL have ports m_ack, m_rd_data  input  1/8  bus acknowledge and combinational read data.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: if any valid is set, SHALL select a winner, register its wr1rd0/addr/data onto m_*, set m_req=1 and go to BUSY at that edge.
REQ-015 Arbitration SHALL be round-robin: with one valid, it wins; with both valid, the requester not granted last wins.
REQ-016 BUSY: m_req and m_* SHALL stay constant until the edge at which m_ack=1 is sampled.
REQ-017 At that edge, m_req SHALL go to 0, m_rd_data SHALL be captured into the winner's rd_data for reads (0x00 for writes), and the FSM SHALL go to RESP.
REQ-018 RESP SHALL last exactly one cycle, with winner done=1 and the other done=0; the next state is IDLE.
REQ-019 Minimum latency SHALL be 3 cycles from valid sampled in IDLE to done: 1 cycle grant, at least 1 cycle BUSY, 1 cycle RESP.
REQ-020 Valid SHALL be ignored outside IDLE; a requester still asserting valid in the cycle after its done SHALL be treated as a new command.
REQ-021 rd_data and err outputs SHALL hold their last values between done pulses.
REQ-022 m_ack while not in BUSY SHALL be ignored.

Reset
REQ-023 Assertion of resetb SHALL immediately force IDLE, m_req=0, m_wr1rd0=0, m_addr=0x00, m_data=0x00, all done=0, all err=0, all rd_data=0x00, and the timeout counter to 0.
REQ-024 Assertion of resetb SHALL set the last-grant flag to r1, so r0 wins the first tie.
REQ-025 A reset during BUSY SHALL abandon the transaction with no done pulse.

Configuration
REQ-026 Macro REG_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without m_ack. When it reaches TIMEOUT_CYCLES, the block SHALL drop m_req, go to RESP with err=1 and rd_data=0xFF.
REQ-027 If m_ack arrives on the same edge the counter reaches TIMEOUT_CYCLES, the ack SHALL take priority and err SHALL be 0.
REQ-028 Macro REG_ARB_TIMEOUT_EN undefined: no counter SHALL exist, err outputs SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-029 Package reg_arb_pkg SHALL hold the FSM state enum, the 8-bit address/data width constants and the 0xFF timeout read value.
REQ-030 The round-robin selector SHALL be a sub-module rr_arb2: inputs valid[1:0], last; output grant index.

Verification
REQ-031 r0 write addr 0x00 data 0xA5, m_ack after 2 BUSY cycles -> m_req high 2 cycles, r0_done at cycle 4, r0_err=0; a following read of 0x00 returns 0xA5.
REQ-032 r0 and r1 valid together from reset, both reads -> r0 served first, then r1; next tie -> r0 after r1, alternating.
REQ-033 r1 read addr 0x02 with m_rd_data=0x50 at ack -> r1_rd_data=0x50 with r1_done, and r0_done stays 0.
REQ-034 Timeout build, TIMEOUT_CYCLES=4, m_ack never asserted -> m_req drops after 4 BUSY cycles, done=1, err=1, rd_data=0xFF.
REQ-035 resetb low mid-BUSY -> m_req=0 immediately, no done; after release, a pending r0 is re-granted from IDLE.
